// File: rtl/pq_arb_pkg.sv
// rtl/pq_arb_pkg.sv - opcode/state types and opcode decode for pq_access_arbiter
// Build option PQ_ARB_TIMEOUT_EN is consumed by rtl/pq_access_arbiter.sv.
package pq_arb_pkg;

  typedef enum logic [1:0] {
    OP_ENQ     = 2'b00,
    OP_DEQ_MIN = 2'b01,
    OP_DEQ_MAX = 2'b10
  } pq_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ENQ,
    SETTLE,
    DEQ_EMPTY,
    DEQ_ISSUE,
    DEQ_WAIT,
    RESCAN
  } arb_state_e;

  // The reserved encoding 2'b11 behaves as dequeue-smallest.
  function automatic pq_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b00:   return OP_ENQ;
      2'b10:   return OP_DEQ_MAX;
      default: return OP_DEQ_MIN;
    endcase
  endfunction

endpackage

// File: rtl/pq_access_arbiter_if.sv
// rtl/pq_access_arbiter_if.sv - requester and priority-queue signals of pq_access_arbiter
// master = requesters plus queue model, slave = the arbiter.
interface pq_access_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
);
  logic [NUM_REQ-1:0]            req_valid_in;
  logic [2*NUM_REQ-1:0]          req_op_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic [NUM_REQ-1:0]            resp_valid_out;
  logic [DATA_WIDTH-1:0]         resp_data_out;
  logic [TAG_WIDTH-1:0]          resp_tag_out;
  logic                          resp_empty_out;
  logic                          resp_err_out;
  logic                          pq_enq_out;
  logic [DATA_WIDTH-1:0]         pq_enq_data_out;
  logic [TAG_WIDTH-1:0]          pq_enq_tag_out;
  logic                          pq_deq_smallest_out;
  logic                          pq_deq_largest_out;
  logic                          pq_full_in;
  logic                          pq_empty_in;
  logic                          pq_valid_in;
  logic [DATA_WIDTH-1:0]         pq_data_in;
  logic [TAG_WIDTH-1:0]          pq_tag_in;
  logic                          pq_stall_in;
  logic                          busy_out;

  modport master (
    output req_valid_in, req_op_in, req_data_in, req_tag_in,
    output pq_full_in, pq_empty_in, pq_valid_in, pq_data_in, pq_tag_in, pq_stall_in,
    input  req_ready_out, resp_valid_out, resp_data_out, resp_tag_out,
    input  resp_empty_out, resp_err_out, pq_enq_out, pq_enq_data_out,
    input  pq_enq_tag_out, pq_deq_smallest_out, pq_deq_largest_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_op_in, req_data_in, req_tag_in,
    input  pq_full_in, pq_empty_in, pq_valid_in, pq_data_in, pq_tag_in, pq_stall_in,
    output req_ready_out, resp_valid_out, resp_data_out, resp_tag_out,
    output resp_empty_out, resp_err_out, pq_enq_out, pq_enq_data_out,
    output pq_enq_tag_out, pq_deq_smallest_out, pq_deq_largest_out, busy_out
  );
endinterface

// File: rtl/pq_access_arbiter_rr_arbiter.sv
// rtl/pq_access_arbiter_rr_arbiter.sv - combinational round-robin pick of first request at or after ptr
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // Scan offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % N]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'((int'(ptr_i) + off) % N);
      end
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// rtl/pq_access_arbiter.sv - round-robin access arbiter sharing one min/max priority queue
// Build option PQ_ARB_TIMEOUT_EN adds a dequeue watchdog that answers with resp_err_out.
module pq_access_arbiter
  import pq_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 32,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk_in,
  input logic rst_in,
  pq_access_arbiter_if.slave arb_if
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_e            state_q;
  logic [IW-1:0]         ptr_q, gnt_q;
  logic [SW-1:0]         settle_q;
  logic [NUM_REQ-1:0]    req_ready_q, resp_valid_q;
  logic [DATA_WIDTH-1:0] enq_data_q, resp_data_q;
  logic [TAG_WIDTH-1:0]  enq_tag_q, resp_tag_q;
  logic                  pq_enq_q, deq_min_q, deq_max_q, resp_empty_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [IW-1:0]         gnt_idx, ptr_d;
  logic                  gnt_valid;
  pq_op_e                gnt_op;

  // Full queue only blocks enqueuers; a rescan in progress blocks everyone.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = arb_if.req_valid_in[i] && !arb_if.pq_stall_in &&
                    ((decode_op(arb_if.req_op_in[2*i +: 2]) != OP_ENQ) || !arb_if.pq_full_in);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i      (eligible),
    .ptr_i      (ptr_q),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  assign gnt_op = decode_op(arb_if.req_op_in[2*int'(gnt_idx) +: 2]);
  assign ptr_d  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef PQ_ARB_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMW-1:0] tmo_q;
  logic           resp_err_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      settle_q     <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      enq_data_q   <= '0;
      enq_tag_q    <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      pq_enq_q     <= 1'b0;
      deq_min_q    <= 1'b0;
      deq_max_q    <= 1'b0;
      resp_empty_q <= 1'b0;
`ifdef PQ_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      pq_enq_q     <= 1'b0;
      deq_min_q    <= 1'b0;
      deq_max_q    <= 1'b0;
      resp_empty_q <= 1'b0;
`ifdef PQ_ARB_TIMEOUT_EN
      resp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: if (gnt_valid) begin
          gnt_q       <= gnt_idx;
          ptr_q       <= ptr_d;
          req_ready_q <= ONE << gnt_idx;
          if (gnt_op == OP_ENQ) begin
            pq_enq_q   <= 1'b1;
            enq_data_q <= arb_if.req_data_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            enq_tag_q  <= arb_if.req_tag_in[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
            state_q    <= ENQ;
          end else if (arb_if.pq_empty_in) begin
            resp_valid_q <= ONE << gnt_idx;
            resp_empty_q <= 1'b1;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            state_q      <= DEQ_EMPTY;
          end else begin
            deq_min_q <= (gnt_op == OP_DEQ_MIN);
            deq_max_q <= (gnt_op == OP_DEQ_MAX);
            state_q   <= DEQ_ISSUE;
          end
        end
        ENQ: begin
          settle_q <= '0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (int'(settle_q) >= SETTLE_CYCLES - 1) state_q <= IDLE;
          else settle_q <= settle_q + 1'b1;
        end
        DEQ_EMPTY: state_q <= IDLE;
        DEQ_ISSUE: state_q <= DEQ_WAIT;
        DEQ_WAIT: if (arb_if.pq_valid_in) begin
          resp_valid_q <= ONE << gnt_q;
          resp_data_q  <= arb_if.pq_data_in;
          resp_tag_q   <= arb_if.pq_tag_in;
          state_q      <= RESCAN;
        end
        RESCAN: if (!arb_if.pq_stall_in) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef PQ_ARB_TIMEOUT_EN
      // Error response shows in the last counted cycle; IDLE follows one cycle later.
      if (state_q == DEQ_WAIT || state_q == RESCAN) begin
        tmo_q <= tmo_q + 1'b1;
        if (state_q == DEQ_WAIT && int'(tmo_q) == TIMEOUT_CYCLES - 2) begin
          resp_valid_q <= ONE << gnt_q;
          resp_err_q   <= 1'b1;
          resp_data_q  <= '0;
          resp_tag_q   <= '0;
        end
        if (int'(tmo_q) == TIMEOUT_CYCLES - 1) begin
          resp_valid_q <= '0;
          state_q      <= IDLE;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  assign arb_if.req_ready_out       = req_ready_q;
  assign arb_if.resp_valid_out      = resp_valid_q;
  assign arb_if.resp_data_out       = resp_data_q;
  assign arb_if.resp_tag_out        = resp_tag_q;
  assign arb_if.resp_empty_out      = resp_empty_q;
  assign arb_if.pq_enq_out          = pq_enq_q;
  assign arb_if.pq_enq_data_out     = enq_data_q;
  assign arb_if.pq_enq_tag_out      = enq_tag_q;
  assign arb_if.pq_deq_smallest_out = deq_min_q;
  assign arb_if.pq_deq_largest_out  = deq_max_q;
  assign arb_if.busy_out            = (state_q != IDLE);
`ifdef PQ_ARB_TIMEOUT_EN
  assign arb_if.resp_err_out        = resp_err_q;
`else
  assign arb_if.resp_err_out        = 1'b0;
`endif

endmodule
